// File: rtl/col_match_engine_if.sv
// C2H AXI-Stream result channel of the column match engine.
// The master side drives one result beat per frame; the slave side provides tready.
interface col_match_engine_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/col_match_engine.sv
// Drains per-column FWFT info/data FIFOs after partition_done, counts beats equal to
// target_i per column, and returns all counts as a single C2H stream beat.
module col_match_engine #(
  parameter int          TCQ          = 1,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned COL_MAX_SIZE = 4
) (
  input  logic                               user_clk,
  input  logic                               user_rst,
  input  logic                               partition_done,
  input  logic [DATA_WIDTH-1:0]              target_i,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] info_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            info_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            info_fifo_rd_en,
  input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] data_fifo_dout,
  input  logic [COL_MAX_SIZE-1:0]            data_fifo_empty,
  output logic [COL_MAX_SIZE-1:0]            data_fifo_rd_en,
  col_match_engine_if.master                 m_axis_c2h,
  output logic                               process_done,
  output logic                               busy
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned ColW     = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(COL_MAX_SIZE - 1);

  // Header field positions are fixed at 128-bit layout; counts are 32 bits per column.
  if (DATA_WIDTH != COL_MAX_SIZE * 32 || DATA_WIDTH < 128 || TCQ < 0) begin : g_bad_params
    $error("col_match_engine: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StInfoHead,
    StInfoSkip,
    StData,
    StNextCol,
    StSend
  } state_e;

  state_e                state_q, state_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [15:0]           len_q, len_d;
  logic [12:0]           skip_q, skip_d;
  logic [12:0]           left_q, left_d;
  logic [31:0]           cnt_q [COL_MAX_SIZE];
  logic [31:0]           cnt_d [COL_MAX_SIZE];
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] info_word, data_word;
  logic [12:0]           head_beats, head_ibeats;
  logic [NumBytes-1:0]   byte_ok;
  logic                  last_partial, beat_match;
  logic                  unused_head;

  always_comb begin
    info_word    = info_fifo_dout[col_q*DATA_WIDTH +: DATA_WIDTH];
    data_word    = data_fifo_dout[col_q*DATA_WIDTH +: DATA_WIDTH];
    head_beats   = {1'b0, info_word[127:116]} + {12'd0, |info_word[115:112]};
    head_ibeats  = {1'b0, info_word[95:84]} + {12'd0, |info_word[83:80]};
    // Only the final beat of a length that is not a multiple of 16 is partially compared.
    last_partial = (left_q == 13'd1) && (len_q[3:0] != 4'd0);
    for (int i = 0; i < int'(NumBytes); i++) begin
      byte_ok[i] = (data_word[8*i +: 8] == target_i[8*i +: 8]) ||
                   (last_partial && (i >= int'(len_q[3:0])));
    end
    beat_match = &byte_ok;
  end

  assign unused_head = ^{info_word[111:96], info_word[79:0]};

  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    len_d           = len_q;
    skip_d          = skip_q;
    left_d          = left_q;
    cnt_d           = cnt_q;
    tdata_d         = tdata_q;
    tvalid_d        = tvalid_q;
    done_d          = 1'b0;
    info_fifo_rd_en = '0;
    data_fifo_rd_en = '0;

    unique case (state_q)
      StIdle: begin
        if (partition_done) begin
          col_d   = '0;
          state_d = StInfoHead;
        end
      end
      StInfoHead: begin
        if (info_fifo_empty[col_q]) begin
          cnt_d[col_q] = '0;
          state_d      = StNextCol;
        end else begin
          info_fifo_rd_en[col_q] = 1'b1;
          len_d  = info_word[127:112];
          left_d = head_beats;
          skip_d = head_ibeats - 13'd1;
          if (head_ibeats > 13'd1)     state_d = StInfoSkip;
          else if (head_beats != '0)   state_d = StData;
          else                         state_d = StNextCol;
        end
      end
      StInfoSkip: begin
        if (!info_fifo_empty[col_q]) begin
          info_fifo_rd_en[col_q] = 1'b1;
          skip_d = skip_q - 13'd1;
          if (skip_q == 13'd1) state_d = (left_q != '0) ? StData : StNextCol;
        end
      end
      StData: begin
        if (!data_fifo_empty[col_q]) begin
          data_fifo_rd_en[col_q] = 1'b1;
          left_d = left_q - 13'd1;
          if (beat_match && (cnt_q[col_q] != 32'hFFFF_FFFF)) begin
            cnt_d[col_q] = cnt_q[col_q] + 32'd1;
          end
          if (left_q == 13'd1) state_d = StNextCol;
        end
      end
      StNextCol: begin
        if (col_q == LastCol) begin
          for (int c = 0; c < int'(COL_MAX_SIZE); c++) tdata_d[c*32 +: 32] = cnt_q[c];
          tvalid_d = 1'b1;
          state_d  = StSend;
        end else begin
          col_d   = col_q + ColW'(1);
          state_d = StInfoHead;
        end
      end
      StSend: begin
        if (m_axis_c2h.tready) begin
          tvalid_d = 1'b0;
          done_d   = 1'b1;
          for (int c = 0; c < int'(COL_MAX_SIZE); c++) cnt_d[c] = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q  <= StIdle;
      col_q    <= '0;
      len_q    <= '0;
      skip_q   <= '0;
      left_q   <= '0;
      for (int c = 0; c < int'(COL_MAX_SIZE); c++) cnt_q[c] <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      len_q    <= len_d;
      skip_q   <= skip_d;
      left_q   <= left_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
    end
  end

  assign m_axis_c2h.tdata  = tdata_q;
  assign m_axis_c2h.tkeep  = {NumBytes{tvalid_q}};
  assign m_axis_c2h.tlast  = tvalid_q;
  assign m_axis_c2h.tvalid = tvalid_q;
  assign process_done      = done_q;
  assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_col_match_engine.sv
// Bench for col_match_engine: queue-based FWFT FIFOs, frame-level match-count model,
// directed frames plus randomized frames, reset abort and duplicate partition_done.
module tb_col_match_engine;
  localparam int unsigned DW = 128;
  localparam int unsigned NC = 4;
  localparam logic [DW-1:0] ONE  = 1;
  localparam logic [DW-1:0] ZERO = 0;

  logic             user_clk = 1'b0;
  logic             user_rst;
  logic             partition_done;
  logic [DW-1:0]    target;
  logic [NC*DW-1:0] info_dout, data_dout;
  logic [NC-1:0]    info_empty, data_empty, info_rd, data_rd;
  logic             process_done, busy;

  col_match_engine_if #(.DATA_WIDTH(DW)) c2h ();

  col_match_engine #(.TCQ(1), .DATA_WIDTH(DW), .COL_MAX_SIZE(NC)) dut (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .partition_done  (partition_done),
    .target_i        (target),
    .info_fifo_dout  (info_dout),
    .info_fifo_empty (info_empty),
    .info_fifo_rd_en (info_rd),
    .data_fifo_dout  (data_dout),
    .data_fifo_empty (data_empty),
    .data_fifo_rd_en (data_rd),
    .m_axis_c2h      (c2h.master),
    .process_done    (process_done),
    .busy            (busy)
  );

  always #5 user_clk = ~user_clk;

  logic [DW-1:0] info_q [NC][$];
  logic [DW-1:0] data_q [NC][$];
  bit            toggle_en;
  int            info_pops [NC];
  int            data_pops [NC];
  int            exp_cnt   [NC];
  int            exp_ipops [NC];
  int            exp_dpops [NC];
  int            rd_violations, n_hs, n_pd;
  int            tests = 0, fails = 0;
  logic [NC-1:0] ir_s, dr_s;

  // FIFO model: present heads at negedge, snapshot rd_en mid-cycle, pop at posedge.
  always begin
    @(negedge user_clk);
    for (int c = 0; c < NC; c++) begin
      info_empty[c] = (info_q[c].size() == 0);
      info_dout[c*DW +: DW] = (info_q[c].size() == 0) ? ZERO : info_q[c][0];
      data_empty[c] = (data_q[c].size() == 0) || (toggle_en && ($urandom_range(0, 1) == 1));
      data_dout[c*DW +: DW] = (data_q[c].size() == 0) ? ZERO : data_q[c][0];
    end
    #1;
    ir_s = info_rd;
    dr_s = data_rd;
    if (((ir_s & info_empty) | (dr_s & data_empty)) != '0) rd_violations++;
    if ($countones(ir_s) > 1 || $countones(dr_s) > 1) rd_violations++;
    if (c2h.tvalid && c2h.tready) n_hs++;
    if (process_done) n_pd++;
    @(posedge user_clk);
    for (int c = 0; c < NC; c++) begin
      if (ir_s[c] && info_q[c].size() > 0) begin
        void'(info_q[c].pop_front());
        info_pops[c]++;
      end
      if (dr_s[c] && data_q[c].size() > 0) begin
        void'(data_q[c].pop_front());
        data_pops[c]++;
      end
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_frame();
    for (int c = 0; c < NC; c++) begin
      info_q[c].delete();
      data_q[c].delete();
      exp_cnt[c]   = 0;
      exp_ipops[c] = 0;
      exp_dpops[c] = 0;
      info_pops[c] = 0;
      data_pops[c] = 0;
    end
  endtask

  // flip: -1 all beats equal target, -2 random byte corruption, >=0 corrupt that byte of
  // the last beat. Expected count comes from comparing the compared bytes directly.
  task automatic load_col(input int c, input int len, input int ifld, input int flip);
    logic [DW-1:0] w;
    int ibeats, beats, valid, b;
    bit match;
    w = rnd128();
    w[127:112] = 16'(len);
    w[95:80]   = 16'(ifld);
    info_q[c].push_back(w);
    ibeats = (ifld + 15) / 16;
    for (int k = 1; k < ibeats; k++) info_q[c].push_back(rnd128());
    exp_ipops[c] = (ibeats > 1) ? ibeats : 1;
    beats = (len + 15) / 16;
    exp_dpops[c] = beats;
    for (int k = 0; k < beats; k++) begin
      w = target;
      b = -1;
      if (flip == -2 && $urandom_range(0, 1) == 1) b = int'($urandom_range(0, 15));
      else if (flip >= 0 && k == beats - 1) b = flip;
      if (b >= 0) w[8*b +: 8] = w[8*b +: 8] ^ 8'($urandom_range(1, 255));
      valid = (k == beats - 1 && len % 16 != 0) ? len % 16 : 16;
      match = 1'b1;
      for (int j = 0; j < valid; j++) if (w[8*j +: 8] != target[8*j +: 8]) match = 1'b0;
      if (match) exp_cnt[c]++;
      data_q[c].push_back(w);
    end
  endtask

  task automatic run_frame(input int hold, input bit dup_pd, input string tag);
    logic [DW-1:0] exp_td;
    int base_hs, base_pd;
    bit got;
    exp_td = '0;
    for (int c = 0; c < NC; c++) exp_td[c*32 +: 32] = 32'(exp_cnt[c]);
    base_hs = n_hs;
    base_pd = n_pd;
    rd_violations = 0;
    @(negedge user_clk);
    partition_done = 1'b1;
    @(negedge user_clk);
    partition_done = 1'b0;
    check({tag, "_busy"}, DW'(busy), ONE);
    got = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      @(negedge user_clk);
      if (dup_pd) partition_done = (cyc == 2);
      if (c2h.tvalid) got = 1'b1;
    end
    partition_done = 1'b0;
    if (!got) begin
      check({tag, "_tvalid_timeout"}, DW'(c2h.tvalid), ONE);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_tvalid_hold"}, DW'(c2h.tvalid), ONE);
      check({tag, "_tdata_hold"}, c2h.tdata, exp_td);
      if (dup_pd) partition_done = (i == 3);
      @(negedge user_clk);
    end
    partition_done = 1'b0;
    check({tag, "_tdata"}, c2h.tdata, exp_td);
    check({tag, "_tkeep"}, DW'(c2h.tkeep), DW'(16'hFFFF));
    check({tag, "_tlast"}, DW'(c2h.tlast), ONE);
    check({tag, "_pd_early"}, DW'(process_done), ZERO);
    c2h.tready = 1'b1;
    @(negedge user_clk);
    c2h.tready = 1'b0;
    check({tag, "_pd_pulse"}, DW'(process_done), ONE);
    check({tag, "_tvalid_drop"}, DW'(c2h.tvalid), ZERO);
    @(negedge user_clk);
    check({tag, "_pd_width"}, DW'(process_done), ZERO);
    check({tag, "_idle"}, DW'(busy), ZERO);
    repeat (20) @(negedge user_clk);
    check({tag, "_beats"}, DW'(n_hs - base_hs), ONE);
    check({tag, "_pd_count"}, DW'(n_pd - base_pd), ONE);
    check({tag, "_rd_while_empty"}, DW'(rd_violations), ZERO);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s_info_pops%0d", tag, c), DW'(info_pops[c]), DW'(exp_ipops[c]));
      check($sformatf("%s_data_pops%0d", tag, c), DW'(data_pops[c]), DW'(exp_dpops[c]));
    end
  endtask

  initial begin
    user_rst       = 1'b1;
    partition_done = 1'b0;
    c2h.tready     = 1'b0;
    toggle_en      = 1'b0;
    target         = '0;
    rd_violations  = 0;
    n_hs           = 0;
    n_pd           = 0;
    clear_frame();
    repeat (3) @(negedge user_clk);
    check("rst_tvalid", DW'(c2h.tvalid), ZERO);
    check("rst_tdata", c2h.tdata, ZERO);
    check("rst_tkeep", DW'(c2h.tkeep), ZERO);
    check("rst_tlast", DW'(c2h.tlast), ZERO);
    check("rst_pd", DW'(process_done), ZERO);
    check("rst_busy", DW'(busy), ZERO);
    check("rst_rd", DW'({info_rd, data_rd}), ZERO);
    user_rst = 1'b0;
    @(negedge user_clk);

    // T1: two full matching beats in column 0 only.
    clear_frame(); target = rnd128();
    load_col(0, 'h20, 0, -1);
    run_frame(0, 1'b0, "t1");
    check("t1_cnt0", DW'(c2h.tdata[31:0]), DW'(2));

    // T2: 0x13 bytes; byte 5 of last beat is beyond the length, byte 1 is not.
    clear_frame(); target = rnd128();
    load_col(0, 'h13, 0, 5);
    run_frame(1, 1'b0, "t2a");
    clear_frame(); target = rnd128();
    load_col(0, 'h13, 0, 1);
    run_frame(1, 1'b0, "t2b");

    // T3: column 1 with two info words and one data beat.
    clear_frame(); target = rnd128();
    load_col(1, 'h10, 'h20, -1);
    run_frame(0, 1'b0, "t3");

    // T4: all columns, column 2 empty payload, data_empty toggling, sink stalls.
    clear_frame(); target = rnd128();
    toggle_en = 1'b1;
    load_col(0, int'($urandom_range(1, 70)), int'($urandom_range(0, 40)), -2);
    load_col(1, int'($urandom_range(1, 70)), int'($urandom_range(0, 40)), -2);
    load_col(2, 0, int'($urandom_range(0, 40)), -2);
    load_col(3, int'($urandom_range(1, 70)), int'($urandom_range(0, 40)), -2);
    run_frame(10, 1'b0, "t4");

    for (int f = 0; f < 5; f++) begin
      clear_frame(); target = rnd128();
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 3) != 0)
          load_col(c, int'($urandom_range(0, 70)), int'($urandom_range(0, 40)), -2);
      end
      toggle_en = ($urandom_range(0, 1) == 1);
      run_frame(int'($urandom_range(0, 5)), 1'b0, "rand");
    end
    toggle_en = 1'b0;

    // T5: asynchronous reset while popping data.
    clear_frame(); target = rnd128();
    load_col(0, 64, 0, -2);
    load_col(1, 48, 20, -2);
    @(negedge user_clk); partition_done = 1'b1;
    @(negedge user_clk); partition_done = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge user_clk);
      #1;
      if (data_rd != '0) break;
    end
    check("t5_in_data", DW'(|data_rd), ONE);
    #1 user_rst = 1'b1;
    #1;
    check("t5_rst_busy", DW'(busy), ZERO);
    check("t5_rst_rd", DW'({info_rd, data_rd}), ZERO);
    check("t5_rst_tvalid", DW'(c2h.tvalid), ZERO);
    check("t5_rst_tdata", c2h.tdata, ZERO);
    check("t5_rst_pd", DW'(process_done), ZERO);
    repeat (2) @(negedge user_clk);
    clear_frame();
    user_rst = 1'b0;
    @(negedge user_clk);
    target = rnd128();
    load_col(0, 40, 0, -2);
    load_col(3, 17, 33, -2);
    run_frame(2, 1'b0, "t5_clean");

    // T6: partition_done repeated while busy and while holding the result.
    clear_frame(); target = rnd128();
    load_col(0, 50, 0, -2);
    load_col(2, 30, 17, -2);
    run_frame(6, 1'b1, "t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
